cu_microsequencer: RTL and testbench

- Microcode sequencer for the CPU control unit.
- Owns the micro-PC (upc) and addresses the combinational microcode ROM.
- Gates the 59-bit control word read from the ROM and passes it to the control-signal field splitter.
- Stalls on memory wait, dispatches on opcode, and enters HALT and interrupt entry.

---
 rtl/cu_microsequencer_pkg.sv | 43 ++++
 rtl/cu_microsequencer_if.sv | 32 +++
 rtl/cu_microsequencer_next_upc.sv | 62 ++++++
 rtl/cu_microsequencer.sv | 96 +++++++++
 tb/tb_cu_microsequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_microsequencer_pkg.sv
// rtl/cu_microsequencer_pkg.sv - shared constants for the control-unit microsequencer
// Purpose: advance-select codes, sequencer state encoding, control-word bit
//          positions and the NOP / write-enable constants.
// Ports:   none (package).
package cu_pkg;

   localparam int UADDR_W_DEF = 9;
   localparam int CW_W_DEF    = 59;

   // adv_sel field of the control word
   localparam logic [1:0] ADV_NEXT     = 2'b00;
   localparam logic [1:0] ADV_DISPATCH = 2'b01;
   localparam logic [1:0] ADV_FETCH    = 2'b10;
   localparam logic [1:0] ADV_BRANCH   = 2'b11;

   // sequencer state register encoding
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam int ADV_LO        = 28;
   localparam int ADV_HI        = 29;
   localparam int DB_NREAD_BIT  = 30;
   localparam int DB_NWRITE_BIT = 2;

   // bus strobes are active-low, so the idle word carries both of them high
   localparam logic [58:0] CW_NOP = (59'd1 << DB_NREAD_BIT) | (59'd1 << DB_NWRITE_BIT);

   localparam logic [58:0] CW_WE_MASK =
        (59'd1 << 2)  | (59'd1 << 19) | (59'd1 << 26) | (59'd1 << 27)
      | (59'd1 << 35) | (59'd1 << 36) | (59'd1 << 37) | (59'd1 << 40)
      | (59'd1 << 48) | (59'd1 << 51) | (59'd1 << 52) | (59'd1 << 56)
      | (59'd1 << 57) | (59'd1 << 58);

   // db_nwrite is active-low: clearing it would start a write, so it is
   // left alone while stalled and only the active-high enables are cleared
   localparam logic [58:0] CW_STALL_CLEAR = CW_WE_MASK & ~(59'd1 << DB_NWRITE_BIT);

   function automatic logic is_mem_op(input logic [58:0] cw);
      return !cw[DB_NREAD_BIT] || !cw[DB_NWRITE_BIT];
   endfunction

endpackage

// File: rtl/cu_microsequencer_if.sv
// rtl/cu_microsequencer_if.sv - microcode ROM / control-unit bundle for the sequencer
// Purpose: groups the ROM address/data, dispatch and condition inputs, the
//          wait/halt/interrupt handshakes and the gated control word.
// Modports: master = sequencer (drives ucode_addr, irq_ack, halted,
//           control_signals); slave = surrounding control unit and ROM.
interface cu_microsequencer_if
   import cu_pkg::*;
#(
   parameter int UADDR_W = UADDR_W_DEF,
   parameter int CW_W    = CW_W_DEF
);
   logic [UADDR_W-1:0] ucode_addr;
   logic [CW_W-1:0]    ucode_data;
   logic [UADDR_W-1:0] dispatch_addr;
   logic               cond_true;
   logic               mem_wait;
   logic               halt_req;
   logic               irq_pending;
   logic               irq_ack;
   logic               halted;
   logic [CW_W-1:0]    control_signals;

   modport master (
      output ucode_addr, irq_ack, halted, control_signals,
      input  ucode_data, dispatch_addr, cond_true, mem_wait, halt_req, irq_pending
   );

   modport slave (
      input  ucode_addr, irq_ack, halted, control_signals,
      output ucode_data, dispatch_addr, cond_true, mem_wait, halt_req, irq_pending
   );
endinterface

// File: rtl/cu_microsequencer_next_upc.sv
// rtl/cu_microsequencer_next_upc.sv - combinational next micro-PC selection
// Purpose: decodes adv_sel, applies stall hold and irq/halt priority, wraps upc+1.
// Ports: upc, adv, dispatch_addr, cond_true, halt_req, irq_pending, in_halt,
//        stall (in); next_upc, take_irq, enter_halt (out).
module cu_next_upc
   import cu_pkg::*;
#(
   parameter int                 UADDR_W = UADDR_W_DEF,
   parameter logic [UADDR_W-1:0] FETCH_A = '0,
   parameter logic [UADDR_W-1:0] IRQ_A   = UADDR_W'(1)
) (
   input  logic [UADDR_W-1:0] upc,
   input  logic [1:0]         adv,
   input  logic [UADDR_W-1:0] dispatch_addr,
   input  logic               cond_true,
   input  logic               halt_req,
   input  logic               irq_pending,
   input  logic               in_halt,
   input  logic               stall,
   output logic [UADDR_W-1:0] next_upc,
   output logic               take_irq,
   output logic               enter_halt
);
   logic [UADDR_W-1:0] upc_inc;

   // natural wrap at 2^UADDR_W
   assign upc_inc = upc + UADDR_W'(1);

   always_comb begin
      next_upc   = upc_inc;
      take_irq   = 1'b0;
      enter_halt = 1'b0;
      if (in_halt) begin
         if (irq_pending) begin
            next_upc = IRQ_A;
            take_irq = 1'b1;
         end else begin
            next_upc = FETCH_A;
         end
      end else if (stall) begin
         // stall outranks everything, including a pending FETCH decision
         next_upc = upc;
      end else begin
         case (adv)
            ADV_NEXT:     next_upc = upc_inc;
            ADV_DISPATCH: next_upc = dispatch_addr;
            ADV_FETCH: begin
               if (irq_pending) begin
                  next_upc = IRQ_A;
                  take_irq = 1'b1;
               end else if (halt_req) begin
                  next_upc   = FETCH_A;
                  enter_halt = 1'b1;
               end else begin
                  next_upc = FETCH_A;
               end
            end
            default:      next_upc = cond_true ? upc_inc : FETCH_A;
         endcase
      end
   end
endmodule

// File: rtl/cu_microsequencer.sv
// rtl/cu_microsequencer.sv - microcode sequencer for the CPU control unit
// Purpose: owns the micro-PC, addresses the microcode ROM, gates the control
//          word (stall write-enable masking, NOP in HALT/reset) and handles
//          memory-wait stalls, HALT and interrupt entry.
// Ports: clk, rst_n (sync active-low); bus (master modport): ucode_addr,
//        ucode_data, dispatch_addr, cond_true, mem_wait, halt_req,
//        irq_pending, irq_ack, halted, control_signals.
module cu_microsequencer
   import cu_pkg::*;
#(
   parameter int          UADDR_W    = UADDR_W_DEF,
   parameter int          CW_W       = CW_W_DEF,
   parameter int unsigned FETCH_ADDR = 0,
   parameter int unsigned IRQ_ADDR   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cu_microsequencer_if.master  bus
);
   localparam logic [UADDR_W-1:0] FETCH_A = UADDR_W'(FETCH_ADDR);
   localparam logic [UADDR_W-1:0] IRQ_A   = UADDR_W'(IRQ_ADDR);

   logic [UADDR_W-1:0] upc;
   logic [UADDR_W-1:0] next_upc;
   logic [1:0]         state;
   logic [1:0]         state_n;
   logic [CW_W-1:0]    cw;
   logic [1:0]         adv;
   logic               in_halt;
   logic               mem_op;
   logic               stall;
   logic               take_irq;
   logic               enter_halt;

   assign cw      = bus.ucode_data;
   assign adv     = cw[ADV_HI:ADV_LO];
   assign in_halt = (state == ST_HALT);
   assign mem_op  = is_mem_op(cw);
   // the STALL state only records the stall; the decision itself is
   // combinational so a ready bus costs no extra cycle
   assign stall   = !in_halt && mem_op && bus.mem_wait;

   cu_next_upc #(
      .UADDR_W (UADDR_W),
      .FETCH_A (FETCH_A),
      .IRQ_A   (IRQ_A)
   ) u_next_upc (
      .upc           (upc),
      .adv           (adv),
      .dispatch_addr (bus.dispatch_addr),
      .cond_true     (bus.cond_true),
      .halt_req      (bus.halt_req),
      .irq_pending   (bus.irq_pending),
      .in_halt       (in_halt),
      .stall         (stall),
      .next_upc      (next_upc),
      .take_irq      (take_irq),
      .enter_halt    (enter_halt)
   );

   always_comb begin
      state_n = ST_RUN;
      if (in_halt) begin
         state_n = take_irq ? ST_RUN : ST_HALT;
      end else if (stall) begin
         state_n = ST_STALL;
      end else if (enter_halt) begin
         state_n = ST_HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         upc   <= FETCH_A;
         state <= ST_RUN;
      end else begin
         upc   <= next_upc;
         state <= state_n;
      end
   end

   always_comb begin
      bus.control_signals = cw;
      if (!rst_n || in_halt) begin
         bus.control_signals = CW_NOP;
      end else if (stall) begin
         // strobes and selects stay asserted; only register writes are held off
         bus.control_signals = cw & ~CW_STALL_CLEAR;
      end
   end

   assign bus.ucode_addr = upc;
   assign bus.irq_ack    = rst_n && take_irq;
   assign bus.halted     = in_halt;

endmodule

// File: tb/tb_cu_microsequencer.sv
// tb/tb_cu_microsequencer.sv - self-checking bench for cu_microsequencer
module tb_cu_microsequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cu_microsequencer_if bus ();

   cu_microsequencer #(
      .UADDR_W    (9),
      .CW_W       (59),
      .FETCH_ADDR (0),
      .IRQ_ADDR   (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam logic [58:0] NOP = 59'h0000_0000_4000_0004;

   logic [58:0] rom [0:511];
   assign bus.ucode_data = rom[bus.ucode_addr];

   logic [58:0] clear_m;
   int          we_bits [13] = '{19, 26, 27, 35, 36, 37, 40, 48, 51, 52, 56, 57, 58};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [58:0] mk(input logic [1:0] adv, input logic nread,
                                      input logic nwrite, input logic [58:0] extra);
      logic [58:0] w;
      w        = extra;
      w[29:28] = adv;
      w[30]    = nread;
      w[2]     = nwrite;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // behavioural model: micro-PC and halted flag, advanced once per edge
   int  m_upc;
   bit  m_halted;
   int  n_upc;
   bit  n_halted;
   bit  check_en = 1'b0;

   always @(negedge clk) begin
      logic [58:0] w;
      logic [58:0] exp_cw;
      bit          exp_ack;
      bit          busy;
      if (check_en) begin
         w        = rom[m_upc];
         exp_cw   = w;
         exp_ack  = 1'b0;
         n_upc    = m_upc;
         n_halted = m_halted;
         if (!rst_n) begin
            exp_cw   = NOP;
            n_upc    = 0;
            n_halted = 1'b0;
         end else if (m_halted) begin
            exp_cw = NOP;
            if (bus.irq_pending) begin
               exp_ack  = 1'b1;
               n_upc    = 1;
               n_halted = 1'b0;
            end else begin
               n_upc = 0;
            end
         end else begin
            busy = (w[30] == 1'b0 || w[2] == 1'b0) && bus.mem_wait;
            if (busy) begin
               exp_cw = w & ~clear_m;
            end else begin
               case (w[29:28])
                  2'd0: n_upc = (m_upc + 1) % 512;
                  2'd1: n_upc = int'(bus.dispatch_addr);
                  2'd2: begin
                     if (bus.irq_pending) begin
                        n_upc   = 1;
                        exp_ack = 1'b1;
                     end else if (bus.halt_req) begin
                        n_upc    = 0;
                        n_halted = 1'b1;
                     end else begin
                        n_upc = 0;
                     end
                  end
                  default: n_upc = bus.cond_true ? (m_upc + 1) % 512 : 0;
               endcase
            end
         end
         chk("model_ucode_addr", 64'(bus.ucode_addr), 64'(m_upc));
         chk("model_halted", 64'(bus.halted), 64'(m_halted));
         chk("model_irq_ack", 64'(bus.irq_ack), 64'(exp_ack));
         chk("model_control", 64'(bus.control_signals), 64'(exp_cw));
      end
   end

   always @(posedge clk) begin
      if (check_en) begin
         m_upc    = n_upc;
         m_halted = n_halted;
      end
   end

   initial begin
      logic [58:0] w;
      clear_m = '0;
      foreach (we_bits[i]) clear_m[we_bits[i]] = 1'b1;
      for (int i = 0; i < 512; i++) rom[i] = NOP;
      bus.dispatch_addr = '0;
      bus.cond_true     = 1'b0;
      bus.mem_wait      = 1'b0;
      bus.halt_req      = 1'b0;
      bus.irq_pending   = 1'b0;

      // reset state
      rst_n = 1'b0;
      tick();
      tick();
      m_upc    = 0;
      m_halted = 1'b0;
      check_en = 1'b1;
      chk("reset_addr", 64'(bus.ucode_addr), 64'h0);
      chk("reset_halted", 64'(bus.halted), 64'h0);
      chk("reset_ack", 64'(bus.irq_ack), 64'h0);
      rst_n = 1'b1;

      // reset mid-routine
      repeat (5) tick();
      chk("run_to_5", 64'(bus.ucode_addr), 64'h5);
      rst_n = 1'b0;
      #1;
      chk("reset_low_nop", 64'(bus.control_signals), 64'(NOP));
      tick();
      chk("reset_mid_addr", 64'(bus.ucode_addr), 64'h0);
      chk("reset_mid_ack", 64'(bus.irq_ack), 64'h0);
      rst_n = 1'b1;

      // dispatch, sequential, wrap
      rom[0] = mk(2'd1, 1'b1, 1'b1, '0);
      bus.dispatch_addr = 9'h123;
      tick();
      chk("dispatch", 64'(bus.ucode_addr), 64'h123);
      rom[0] = NOP;
      tick();
      chk("next", 64'(bus.ucode_addr), 64'h124);
      rom[9'h124] = mk(2'd1, 1'b1, 1'b1, '0);
      bus.dispatch_addr = 9'h1FF;
      tick();
      chk("to_1ff", 64'(bus.ucode_addr), 64'h1FF);
      tick();
      chk("wrap", 64'(bus.ucode_addr), 64'h0);
      tick();
      chk("after_wrap", 64'(bus.ucode_addr), 64'h1);

      // stall: read with bit36 set, three wait cycles
      rom[1] = mk(2'd0, 1'b0, 1'b1, 59'd1 << 36);
      bus.mem_wait = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_bit36", 64'(bus.control_signals[36]), 64'h0);
         chk("stall_bit30", 64'(bus.control_signals[30]), 64'h0);
         tick();
         chk("stall_hold", 64'(bus.ucode_addr), 64'h1);
      end
      bus.mem_wait = 1'b0;
      #1;
      chk("unstall_bit36", 64'(bus.control_signals[36]), 64'h1);
      tick();
      chk("unstall_adv", 64'(bus.ucode_addr), 64'h2);

      // branch
      rom[2] = mk(2'd1, 1'b1, 1'b1, '0);
      bus.dispatch_addr = 9'h040;
      tick();
      chk("to_40", 64'(bus.ucode_addr), 64'h40);
      rom[9'h40] = mk(2'd3, 1'b1, 1'b1, '0);
      bus.cond_true = 1'b1;
      tick();
      chk("branch_taken", 64'(bus.ucode_addr), 64'h41);
      rom[9'h41] = mk(2'd1, 1'b1, 1'b1, '0);
      tick();
      chk("back_40", 64'(bus.ucode_addr), 64'h40);
      bus.cond_true = 1'b0;
      tick();
      chk("branch_not", 64'(bus.ucode_addr), 64'h0);

      // HALT then interrupt wake-up
      rom[0] = mk(2'd2, 1'b1, 1'b1, '0);
      bus.halt_req = 1'b1;
      tick();
      chk("halt_enter", 64'(bus.halted), 64'h1);
      chk("halt_addr", 64'(bus.ucode_addr), 64'h0);
      repeat (10) begin
         #1;
         chk("halt_nop", 64'(bus.control_signals), 64'(NOP));
         tick();
         chk("halt_stay", 64'(bus.halted), 64'h1);
      end
      bus.irq_pending = 1'b1;
      #1;
      chk("wake_ack", 64'(bus.irq_ack), 64'h1);
      tick();
      chk("wake_addr", 64'(bus.ucode_addr), 64'h1);
      chk("wake_halted", 64'(bus.halted), 64'h0);
      bus.irq_pending = 1'b0;
      bus.halt_req    = 1'b0;
      #1;
      chk("wake_ack_pulse", 64'(bus.irq_ack), 64'h0);

      // stall > irq > halt in the FETCH cycle
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rom[0] = mk(2'd2, 1'b0, 1'b1, '0);
      bus.halt_req    = 1'b1;
      bus.irq_pending = 1'b1;
      bus.mem_wait    = 1'b1;
      #1;
      chk("simul_stall_ack", 64'(bus.irq_ack), 64'h0);
      tick();
      chk("simul_hold", 64'(bus.ucode_addr), 64'h0);
      chk("simul_not_halted", 64'(bus.halted), 64'h0);
      bus.mem_wait = 1'b0;
      #1;
      chk("simul_ack", 64'(bus.irq_ack), 64'h1);
      tick();
      chk("simul_irq_addr", 64'(bus.ucode_addr), 64'h1);
      chk("simul_no_halt", 64'(bus.halted), 64'h0);
      bus.halt_req    = 1'b0;
      bus.irq_pending = 1'b0;

      // randomized run against the model
      for (int i = 0; i < 512; i++) begin
         w     = 59'({$urandom(), $urandom()});
         w[30] = ($urandom_range(3) != 0);
         w[2]  = ($urandom_range(3) != 0);
         rom[i] = w;
      end
      for (int c = 0; c < 3000; c++) begin
         bus.dispatch_addr = 9'($urandom_range(511));
         bus.cond_true     = 1'($urandom_range(1));
         bus.mem_wait      = ($urandom_range(2) == 0);
         bus.halt_req      = ($urandom_range(3) == 0);
         bus.irq_pending   = ($urandom_range(7) == 0);
         rst_n             = ($urandom_range(99) != 0);
         tick();
      end

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
